// File: rtl/reg_scoreboard_if.sv
// Decode/write-back interlock bus between the pipeline and reg_scoreboard.
// master: pipeline side, drives decode and write-back info and reads status.
// slave : scoreboard side, returns stall/issue (combinational) and
//         inflight/busy/err (derived from registered state).
interface reg_scoreboard_if;
    logic       dec_valid;
    logic [4:0] dec_rs1;
    logic [4:0] dec_rs2;
    logic       dec_use_rs1;
    logic       dec_use_rs2;
    logic [4:0] dec_rd;
    logic       dec_wr;
    logic       wb_valid;
    logic [4:0] wb_rd;
    logic       flush;
    logic       stall;
    logic       issue;
    logic [3:0] inflight;
    logic       busy;
    logic       err;

    modport master (
        output dec_valid, dec_rs1, dec_rs2, dec_use_rs1, dec_use_rs2,
        output dec_rd, dec_wr, wb_valid, wb_rd, flush,
        input  stall, issue, inflight, busy, err
    );

    modport slave (
        input  dec_valid, dec_rs1, dec_rs2, dec_use_rs1, dec_use_rs2,
        input  dec_rd, dec_wr, wb_valid, wb_rd, flush,
        output stall, issue, inflight, busy, err
    );
endinterface

// File: rtl/reg_scoreboard.sv
// Register-file interlock: counts in-flight writes per architectural register
// and holds decode while a source is pending or tracking would overflow.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset (overrides flush and all inputs)
//   bus  - reg_scoreboard_if.slave: decode/write-back inputs, stall/issue
//          (combinational), inflight/busy/err (from registered state)
module reg_scoreboard #(
    parameter int unsigned CNT_W        = 2,
    parameter int unsigned MAX_INFLIGHT = 4
) (
    input  logic             clk,
    input  logic             rst,
    reg_scoreboard_if.slave  bus
);
    localparam int unsigned NREG  = 32;
    localparam int unsigned INF_W = 4;
    localparam logic [CNT_W-1:0] PEND_MAX = '1;

    // Entry 0 is never incremented, so x0 always reads as not pending.
    logic [CNT_W-1:0] pend_q [NREG];
    logic [INF_W-1:0] inflight_q;
    logic             err_q;

    logic [CNT_W-1:0] pend_rs1, pend_rs2, pend_rd, pend_wb;
    logic             rd_nz, wb_nz;
    logic             raw1, raw2, waw_full, cap_full;
    logic             stall_c, issue_c;
    logic             set, clr, wb_bad;
    logic [NREG-1:0]  set_mask, clr_mask;

    // Hazard evaluation on registered state only; no write-back bypass.
    always_comb begin
        pend_rs1 = pend_q[bus.dec_rs1];
        pend_rs2 = pend_q[bus.dec_rs2];
        pend_rd  = pend_q[bus.dec_rd];
        pend_wb  = pend_q[bus.wb_rd];
        rd_nz    = (bus.dec_rd != 5'd0);
        wb_nz    = (bus.wb_rd != 5'd0);

        raw1     = bus.dec_use_rs1 && (bus.dec_rs1 != 5'd0) && (pend_rs1 != '0);
        raw2     = bus.dec_use_rs2 && (bus.dec_rs2 != 5'd0) && (pend_rs2 != '0);
        waw_full = bus.dec_wr && rd_nz && (pend_rd == PEND_MAX);
        cap_full = bus.dec_wr && rd_nz && (inflight_q == INF_W'(MAX_INFLIGHT));

        stall_c  = bus.dec_valid && (raw1 || raw2 || waw_full || cap_full);
        issue_c  = bus.dec_valid && !stall_c;

        set      = issue_c && bus.dec_wr && rd_nz;
        clr      = bus.wb_valid && wb_nz && (pend_wb != '0);
        wb_bad   = bus.wb_valid && wb_nz && (pend_wb == '0);

        set_mask = set ? (NREG'(1) << bus.dec_rd) : '0;
        clr_mask = clr ? (NREG'(1) << bus.wb_rd)  : '0;
    end

    assign bus.stall    = stall_c;
    assign bus.issue    = issue_c;
    assign bus.inflight = inflight_q;
    assign bus.busy     = (inflight_q != '0);
    assign bus.err      = err_q;

    // Counter update; set and clr on the same register cancel out.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) pend_q[i] <= '0;
            inflight_q <= '0;
            err_q      <= 1'b0;
        end else if (bus.flush) begin
            for (int i = 0; i < NREG; i++) pend_q[i] <= '0;
            inflight_q <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (set_mask[i] && !clr_mask[i])
                    pend_q[i] <= pend_q[i] + CNT_W'(1);
                else if (clr_mask[i] && !set_mask[i])
                    pend_q[i] <= pend_q[i] - CNT_W'(1);
            end
            if (set && !clr)
                inflight_q <= inflight_q + INF_W'(1);
            else if (clr && !set)
                inflight_q <= inflight_q - INF_W'(1);
            if (wb_bad)
                err_q <= 1'b1;
        end
    end
endmodule
